// File: rtl/seg_scan_reader.sv
// seg_scan_reader: recovers BCD codes from a multiplexed active-low 7-segment bus.
// Define SEG_READER_SYNC_EN to add a two-flop input synchronizer ahead of the sample register.
module seg_scan_reader #(
    parameter int NUM_DIGITS    = 6,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [6:0]              seg,
    input  logic [NUM_DIGITS-1:0]   an,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [NUM_DIGITS-1:0]   digit_vld,
    output logic                    commit,
    output logic                    bad_pat,
    output logic                    frame_done,
    output logic [7:0]              err_cnt
);
    typedef enum logic [1:0] {IDLE = 2'd0, SETTLE = 2'd1, HOLD = 2'd2} state_t;

    localparam logic [7:0] STABLE_U8 = 8'(STABLE_CYCLES);

    function automatic logic [3:0] seg_decode(input logic [6:0] pat);
        case (pat)
            7'b1000000: seg_decode = 4'd0;
            7'b1111001: seg_decode = 4'd1;
            7'b0100100: seg_decode = 4'd2;
            7'b0110000: seg_decode = 4'd3;
            7'b0011001: seg_decode = 4'd4;
            7'b0010010: seg_decode = 4'd5;
            7'b0000010: seg_decode = 4'd6;
            7'b1111000: seg_decode = 4'd7;
            7'b0000000: seg_decode = 4'd8;
            7'b0011000: seg_decode = 4'd9;
            7'b1111111: seg_decode = 4'hF;
            default:    seg_decode = 4'hE;
        endcase
    endfunction

    logic [6:0]              in_seg_s;
    logic [NUM_DIGITS-1:0]   in_an_s;
    logic [6:0]              s_seg_q, p_seg_q;
    logic [NUM_DIGITS-1:0]   s_an_q, p_an_q;
    state_t                  state_q, state_d;
    logic [7:0]              cnt_q, cnt_d;
    logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
    logic [NUM_DIGITS-1:0]   vld_q, vld_d;
    logic [NUM_DIGITS-1:0]   mask_q, mask_d;
    logic                    commit_q, commit_d;
    logic                    bad_q, bad_d;
    logic                    frame_q, frame_d;
    logic [7:0]              err_q, err_d;
    logic                    legal_s, same_s, commit_now_s;
    logic [3:0]              code_s;
    logic [NUM_DIGITS-1:0]   mask_next_s;

`ifdef SEG_READER_SYNC_EN
    logic [6:0]            sync1_seg_q, sync2_seg_q;
    logic [NUM_DIGITS-1:0] sync1_an_q, sync2_an_q;

    // Two-flop synchronizer; resets to a dark display (all lines high).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_seg_q <= '1;
            sync2_seg_q <= '1;
            sync1_an_q  <= '1;
            sync2_an_q  <= '1;
        end else begin
            sync1_seg_q <= seg;
            sync2_seg_q <= sync1_seg_q;
            sync1_an_q  <= an;
            sync2_an_q  <= sync1_an_q;
        end
    end

    assign in_seg_s = sync2_seg_q;
    assign in_an_s  = sync2_an_q;
`else
    assign in_seg_s = seg;
    assign in_an_s  = an;
`endif

    assign legal_s = $onehot(~s_an_q);
    assign same_s  = (s_seg_q == p_seg_q) && (s_an_q == p_an_q);
    assign code_s  = seg_decode(s_seg_q);

    // Next-state: stability FSM plus commit side effects on the stable sample.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        digits_d     = digits_q;
        vld_d        = vld_q;
        mask_d       = mask_q;
        err_d        = err_q;
        commit_d     = 1'b0;
        bad_d        = 1'b0;
        frame_d      = 1'b0;
        commit_now_s = 1'b0;
        mask_next_s  = mask_q | ~s_an_q;

        case (state_q)
            IDLE: begin
                if (legal_s) begin
                    state_d = SETTLE;
                    cnt_d   = 8'd1;
                end else begin
                    state_d = IDLE;
                end
            end
            SETTLE: begin
                if (!legal_s) begin
                    state_d = IDLE;
                    cnt_d   = 8'd0;
                end else if (!same_s) begin
                    cnt_d = 8'd1;
                end else if (cnt_q + 8'd1 == STABLE_U8) begin
                    commit_now_s = 1'b1;
                    state_d      = HOLD;
                    cnt_d        = STABLE_U8;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            HOLD: begin
                if (!legal_s) begin
                    state_d = IDLE;
                    cnt_d   = 8'd0;
                end else if (!same_s) begin
                    state_d = SETTLE;
                    cnt_d   = 8'd1;
                end else begin
                    state_d = HOLD;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 8'd0;
            end
        endcase

        if (commit_now_s) begin
            commit_d = 1'b1;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (!s_an_q[i]) begin
                    digits_d[4*i +: 4] = code_s;
                    vld_d[i]           = 1'b1;
                end
            end
            if (code_s == 4'hE) begin
                bad_d = 1'b1;
                err_d = (err_q == 8'hFF) ? err_q : err_q + 8'd1;
            end else begin
                bad_d = 1'b0;
            end
            if (&mask_next_s) begin
                frame_d = 1'b1;
                mask_d  = '0;
            end else begin
                mask_d  = mask_next_s;
            end
        end else begin
            commit_d = 1'b0;
        end
    end

    // Sample registers, FSM state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_seg_q  <= '0;
            s_an_q   <= '0;
            p_seg_q  <= '0;
            p_an_q   <= '0;
            state_q  <= IDLE;
            cnt_q    <= 8'd0;
            digits_q <= '0;
            vld_q    <= '0;
            mask_q   <= '0;
            commit_q <= 1'b0;
            bad_q    <= 1'b0;
            frame_q  <= 1'b0;
            err_q    <= 8'd0;
        end else begin
            s_seg_q  <= in_seg_s;
            s_an_q   <= in_an_s;
            p_seg_q  <= s_seg_q;
            p_an_q   <= s_an_q;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            digits_q <= digits_d;
            vld_q    <= vld_d;
            mask_q   <= mask_d;
            commit_q <= commit_d;
            bad_q    <= bad_d;
            frame_q  <= frame_d;
            err_q    <= err_d;
        end
    end

    assign digits     = digits_q;
    assign digit_vld  = vld_q;
    assign commit     = commit_q;
    assign bad_pat    = bad_q;
    assign frame_done = frame_q;
    assign err_cnt    = err_q;
endmodule
